// File: rtl/xbar_pkg.sv
// Shared constants and ID helpers for the crossbar ports.
package xbar_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // Width of a master index; never zero so single-master builds still elaborate.
    function automatic int unsigned mst_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [63:0] id_tag(input logic [63:0] m, input logic [63:0] id,
                                           input int unsigned id_width);
        return (m << id_width) | id;
    endfunction

    function automatic logic [63:0] id_untag(input logic [63:0] id, input int unsigned id_width,
                                             input int unsigned mst_w);
        return (id >> id_width) & ((64'd1 << mst_w) - 64'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest-numbered requester at or after the pointer wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [0:N-1]  req,
    input  logic          advance,
    output logic [0:N-1]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] ptr;
    logic          found;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found     = 1'b1;
                grant_idx = IW'((int'(ptr) + k) % N);
            end
        end
        if (found && advance) grant[grant_idx] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                ptr <= '0;
        else if (found && advance) ptr <= IW'((int'(grant_idx) + 1) % N);
    end

endmodule

// File: rtl/xbar_master_interface.sv
// Crossbar port facing one outer AXI slave: AR/AW arbitration with ID tagging,
// W steering in AW-grant order, and single-entry R/B response slices.
module xbar_master_interface
    import xbar_pkg::*;
#(
    parameter int ID_WIDTH          = 4,
    parameter int IDS_WIDTH         = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int LEN_WIDTH         = 4,
    parameter int SIZE_WIDTH        = 3,
    parameter int DATA_WIDTH        = 32,
    parameter int STRB_WIDTH        = 4,
    parameter int masters           = 2,
    parameter int slaves            = 2,
    parameter int i_am_slave_number = 0,
    parameter int pending_depth     = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [0:masters-1]     ar_req,
    input  logic [ID_WIDTH-1:0]    ARID_X    [masters],
    input  logic [ADDR_WIDTH-1:0]  ARADDR_X  [masters],
    input  logic [LEN_WIDTH-1:0]   ARLEN_X   [masters],
    input  logic [SIZE_WIDTH-1:0]  ARSIZE_X  [masters],
    input  logic [1:0]             ARBURST_X [masters],
    output logic [0:masters-1]     ar_grant,
    input  logic [0:masters-1]     aw_req,
    input  logic [ID_WIDTH-1:0]    AWID_X    [masters],
    input  logic [ADDR_WIDTH-1:0]  AWADDR_X  [masters],
    input  logic [LEN_WIDTH-1:0]   AWLEN_X   [masters],
    input  logic [SIZE_WIDTH-1:0]  AWSIZE_X  [masters],
    input  logic [1:0]             AWBURST_X [masters],
    output logic [0:masters-1]     aw_grant,
    input  logic [0:masters-1]     w_valid,
    input  logic [DATA_WIDTH-1:0]  WDATA_X   [masters],
    input  logic [STRB_WIDTH-1:0]  WSTRB_X   [masters],
    input  logic                   WLAST_X   [masters],
    output logic [0:masters-1]     w_pop,
    output logic                   r_empty,
    output logic [mst_width(masters)-1:0] r_dest_master,
    output logic [ID_WIDTH-1:0]    RID,
    output logic [DATA_WIDTH-1:0]  RDATA,
    output logic [1:0]             RRESP,
    output logic                   RLAST,
    input  logic [0:masters-1]     r_pop,
    output logic                   b_empty,
    output logic [mst_width(masters)-1:0] b_dest_master,
    output logic [ID_WIDTH-1:0]    BID,
    output logic [1:0]             BRESP,
    input  logic [0:masters-1]     b_pop,
    output logic [IDS_WIDTH-1:0]   ARID_S,
    output logic [ADDR_WIDTH-1:0]  ARADDR_S,
    output logic [LEN_WIDTH-1:0]   ARLEN_S,
    output logic [SIZE_WIDTH-1:0]  ARSIZE_S,
    output logic [1:0]             ARBURST_S,
    output logic                   ARVALID_S,
    input  logic                   ARREADY_S,
    output logic [IDS_WIDTH-1:0]   AWID_S,
    output logic [ADDR_WIDTH-1:0]  AWADDR_S,
    output logic [LEN_WIDTH-1:0]   AWLEN_S,
    output logic [SIZE_WIDTH-1:0]  AWSIZE_S,
    output logic [1:0]             AWBURST_S,
    output logic                   AWVALID_S,
    input  logic                   AWREADY_S,
    output logic [DATA_WIDTH-1:0]  WDATA_S,
    output logic [STRB_WIDTH-1:0]  WSTRB_S,
    output logic                   WLAST_S,
    output logic                   WVALID_S,
    input  logic                   WREADY_S,
    input  logic [IDS_WIDTH-1:0]   RID_S,
    input  logic [DATA_WIDTH-1:0]  RDATA_S,
    input  logic [1:0]             RRESP_S,
    input  logic                   RLAST_S,
    input  logic                   RVALID_S,
    output logic                   RREADY_S,
    input  logic [IDS_WIDTH-1:0]   BID_S,
    input  logic [1:0]             BRESP_S,
    input  logic                   BVALID_S,
    output logic                   BREADY_S
);
    localparam int MST_W = mst_width(masters);
    localparam int QW    = (pending_depth > 1) ? $clog2(pending_depth) : 1;
    localparam int CW    = $clog2(pending_depth + 1);

    if (IDS_WIDTH < ID_WIDTH + $clog2(masters)) begin : g_ids_check
        $error("IDS_WIDTH cannot hold the master tag");
    end
    if (i_am_slave_number >= slaves) begin : g_port_check
        $error("i_am_slave_number out of range");
    end

    // ---------------- AR ----------------
    logic             ar_free;
    logic [MST_W-1:0] ar_idx;
    logic [63:0]      ar_tag;

    assign ar_free = ~ARVALID_S | ARREADY_S;
    assign ar_tag  = id_tag(64'(ar_idx), 64'(ARID_X[ar_idx]), ID_WIDTH);

    rr_arbiter #(.N(masters), .IW(MST_W)) u_ar_arb (
        .clk(ACLK), .rst_n(ARESETn), .req(ar_req), .advance(ar_free),
        .grant(ar_grant), .grant_idx(ar_idx)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ARVALID_S <= 1'b0;
            ARID_S    <= '0;
            ARADDR_S  <= '0;
            ARLEN_S   <= '0;
            ARSIZE_S  <= '0;
            ARBURST_S <= '0;
        end else if (|ar_grant) begin
            ARVALID_S <= 1'b1;
            ARID_S    <= ar_tag[IDS_WIDTH-1:0];
            ARADDR_S  <= ARADDR_X[ar_idx];
            ARLEN_S   <= ARLEN_X[ar_idx];
            ARSIZE_S  <= ARSIZE_X[ar_idx];
            ARBURST_S <= ARBURST_X[ar_idx];
        end else if (ARREADY_S) begin
            ARVALID_S <= 1'b0;
        end
    end

    // ---------------- AW + W-order queue ----------------
    logic             aw_free;
    logic [MST_W-1:0] aw_idx;
    logic [63:0]      aw_tag;
    logic [MST_W-1:0] wq_mem [pending_depth];
    logic [QW-1:0]    wq_rd, wq_wr;
    logic [CW-1:0]    wq_count;
    logic             wq_empty, wq_full, wq_push, wq_pop;
    logic [MST_W-1:0] w_head;

    assign wq_empty = (wq_count == '0);
    assign wq_full  = (wq_count == CW'(pending_depth));
    // A full queue blocks AW even when WLAST frees a slot in the same cycle.
    assign aw_free  = (~AWVALID_S | AWREADY_S) & ~wq_full;
    assign aw_tag   = id_tag(64'(aw_idx), 64'(AWID_X[aw_idx]), ID_WIDTH);
    assign wq_push  = |aw_grant;
    assign wq_pop   = WVALID_S & WREADY_S & WLAST_S;

    rr_arbiter #(.N(masters), .IW(MST_W)) u_aw_arb (
        .clk(ACLK), .rst_n(ARESETn), .req(aw_req), .advance(aw_free),
        .grant(aw_grant), .grant_idx(aw_idx)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            AWVALID_S <= 1'b0;
            AWID_S    <= '0;
            AWADDR_S  <= '0;
            AWLEN_S   <= '0;
            AWSIZE_S  <= '0;
            AWBURST_S <= '0;
        end else if (wq_push) begin
            AWVALID_S <= 1'b1;
            AWID_S    <= aw_tag[IDS_WIDTH-1:0];
            AWADDR_S  <= AWADDR_X[aw_idx];
            AWLEN_S   <= AWLEN_X[aw_idx];
            AWSIZE_S  <= AWSIZE_X[aw_idx];
            AWBURST_S <= AWBURST_X[aw_idx];
        end else if (AWREADY_S) begin
            AWVALID_S <= 1'b0;
        end
    end

    // NOTE: queue storage has no reset; only the pointers and count define validity.
    always_ff @(posedge ACLK) begin
        if (wq_push) wq_mem[wq_wr] <= aw_idx;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wq_rd    <= '0;
            wq_wr    <= '0;
            wq_count <= '0;
        end else begin
            if (wq_push) wq_wr <= (int'(wq_wr) == pending_depth - 1) ? '0 : wq_wr + QW'(1);
            if (wq_pop)  wq_rd <= (int'(wq_rd) == pending_depth - 1) ? '0 : wq_rd + QW'(1);
            case ({wq_push, wq_pop})
                2'b10:   wq_count <= wq_count + CW'(1);
                2'b01:   wq_count <= wq_count - CW'(1);
                default: wq_count <= wq_count;
            endcase
        end
    end

    always_comb begin
        w_head   = wq_mem[wq_rd];
        WVALID_S = 1'b0;
        WDATA_S  = '0;
        WSTRB_S  = '0;
        WLAST_S  = 1'b0;
        w_pop    = '0;
        if (!wq_empty) begin
            WVALID_S      = w_valid[w_head];
            WDATA_S       = WDATA_X[w_head];
            WSTRB_S       = WSTRB_X[w_head];
            WLAST_S       = WLAST_X[w_head];
            w_pop[w_head] = w_valid[w_head] & WREADY_S;
        end
    end

    // ---------------- R / B slices ----------------
    logic        r_full, b_full;
    logic [63:0] r_dest, b_dest;

    assign r_empty  = ~r_full;
    assign b_empty  = ~b_full;
    assign RREADY_S = ~r_full | (|r_pop);
    assign BREADY_S = ~b_full | (|b_pop);
    assign r_dest   = id_untag(64'(RID_S), ID_WIDTH, MST_W);
    assign b_dest   = id_untag(64'(BID_S), ID_WIDTH, MST_W);

    // A response whose tag names no existing master is accepted and silently dropped.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_full        <= 1'b0;
            r_dest_master <= '0;
            RID           <= '0;
            RDATA         <= '0;
            RRESP         <= '0;
            RLAST         <= 1'b0;
        end else if (RVALID_S & RREADY_S) begin
            r_full        <= (r_dest < 64'(masters));
            r_dest_master <= r_dest[MST_W-1:0];
            RID           <= RID_S[ID_WIDTH-1:0];
            RDATA         <= RDATA_S;
            RRESP         <= RRESP_S;
            RLAST         <= RLAST_S;
        end else if (|r_pop) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            b_full        <= 1'b0;
            b_dest_master <= '0;
            BID           <= '0;
            BRESP         <= '0;
        end else if (BVALID_S & BREADY_S) begin
            b_full        <= (b_dest < 64'(masters));
            b_dest_master <= b_dest[MST_W-1:0];
            BID           <= BID_S[ID_WIDTH-1:0];
            BRESP         <= BRESP_S;
        end else if (|b_pop) begin
            b_full <= 1'b0;
        end
    end

    r_pop_onehot: assert property (@(posedge ACLK) disable iff (!ARESETn) $onehot0(r_pop));
    b_pop_onehot: assert property (@(posedge ACLK) disable iff (!ARESETn) $onehot0(b_pop));

endmodule

// File: tb/tb_xbar_master_interface.sv
// Directed and randomized checks of the crossbar slave-side port against a queue-based reference.
module tb_xbar_master_interface;
    import xbar_pkg::*;

    localparam int M = 2, IDW = 4, IDSW = 8, AW = 32, LW = 4, SW = 3, DW = 32, STW = 4, PD = 2;

    logic ACLK = 1'b0, ARESETn;
    logic [0:M-1] ar_req, ar_grant, aw_req, aw_grant, w_valid, w_pop, r_pop, b_pop;
    logic [IDW-1:0] ARID_X [M], AWID_X [M];
    logic [AW-1:0]  ARADDR_X [M], AWADDR_X [M];
    logic [LW-1:0]  ARLEN_X [M], AWLEN_X [M];
    logic [SW-1:0]  ARSIZE_X [M], AWSIZE_X [M];
    logic [1:0]     ARBURST_X [M], AWBURST_X [M];
    logic [DW-1:0]  WDATA_X [M];
    logic [STW-1:0] WSTRB_X [M];
    logic           WLAST_X [M];
    logic r_empty, b_empty, RLAST;
    logic [0:0] r_dest_master, b_dest_master;
    logic [IDW-1:0] RID, BID;
    logic [DW-1:0] RDATA;
    logic [1:0] RRESP, BRESP;
    logic [IDSW-1:0] ARID_S, AWID_S, RID_S, BID_S;
    logic [AW-1:0] ARADDR_S, AWADDR_S;
    logic [LW-1:0] ARLEN_S, AWLEN_S;
    logic [SW-1:0] ARSIZE_S, AWSIZE_S;
    logic [1:0] ARBURST_S, AWBURST_S, RRESP_S, BRESP_S;
    logic ARVALID_S, ARREADY_S, AWVALID_S, AWREADY_S, WLAST_S, WVALID_S, WREADY_S;
    logic [DW-1:0] WDATA_S, RDATA_S;
    logic [STW-1:0] WSTRB_S;
    logic RLAST_S, RVALID_S, RREADY_S, BVALID_S, BREADY_S;

    xbar_master_interface #(
        .ID_WIDTH(IDW), .IDS_WIDTH(IDSW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW),
        .DATA_WIDTH(DW), .STRB_WIDTH(STW), .masters(M), .slaves(2), .i_am_slave_number(0),
        .pending_depth(PD)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ar_req(ar_req), .ARID_X(ARID_X), .ARADDR_X(ARADDR_X), .ARLEN_X(ARLEN_X),
        .ARSIZE_X(ARSIZE_X), .ARBURST_X(ARBURST_X), .ar_grant(ar_grant),
        .aw_req(aw_req), .AWID_X(AWID_X), .AWADDR_X(AWADDR_X), .AWLEN_X(AWLEN_X),
        .AWSIZE_X(AWSIZE_X), .AWBURST_X(AWBURST_X), .aw_grant(aw_grant),
        .w_valid(w_valid), .WDATA_X(WDATA_X), .WSTRB_X(WSTRB_X), .WLAST_X(WLAST_X), .w_pop(w_pop),
        .r_empty(r_empty), .r_dest_master(r_dest_master), .RID(RID), .RDATA(RDATA),
        .RRESP(RRESP), .RLAST(RLAST), .r_pop(r_pop),
        .b_empty(b_empty), .b_dest_master(b_dest_master), .BID(BID), .BRESP(BRESP), .b_pop(b_pop),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S)
    );

    always #5 ACLK = ~ACLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:M-1] oh(input int m);
        logic [0:M-1] v;
        v    = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference state
    int            ar_ptr, win;
    logic          ar_v;
    logic [7:0]    ar_id;
    int            wq[$];
    logic [31:0]   rd[4];
    logic [31:0]   held;
    int unsigned   sq_dest[$];
    logic [3:0]    sq_id[$];
    logic [31:0]   sq_data[$];
    logic          exp_ready;

    initial begin
        ARESETn = 1'b0;
        ar_req = '0; aw_req = '0; w_valid = '0; r_pop = '0; b_pop = '0;
        for (int m = 0; m < M; m++) begin
            ARID_X[m] = '0; ARADDR_X[m] = '0; ARLEN_X[m] = '0; ARSIZE_X[m] = 3'd2;
            ARBURST_X[m] = AXI_BURST_INCR;
            AWID_X[m] = '0; AWADDR_X[m] = '0; AWLEN_X[m] = '0; AWSIZE_X[m] = 3'd2;
            AWBURST_X[m] = AXI_BURST_INCR;
            WDATA_X[m] = '0; WSTRB_X[m] = '1; WLAST_X[m] = 1'b0;
        end
        ARREADY_S = 1'b0; AWREADY_S = 1'b0; WREADY_S = 1'b0;
        RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0; RVALID_S = 1'b0;
        BID_S = '0; BRESP_S = '0; BVALID_S = 1'b0;
        repeat (2) step();
        check("rst_arvalid", ARVALID_S, 0);
        check("rst_awvalid", AWVALID_S, 0);
        check("rst_wvalid", WVALID_S, 0);
        check("rst_r_empty", r_empty, 1);
        check("rst_b_empty", b_empty, 1);
        ARESETn = 1'b1;
        step();

        // 1: single AR from master 1
        ar_req[1] = 1'b1; ARID_X[1] = 4'h3; ARADDR_X[1] = 32'h1000_0040;
        #1 check("t1_grant", ar_grant, oh(1));
        step();
        ar_req = '0;
        #1 check("t1_arvalid", ARVALID_S, 1);
        check("t1_arid", ARID_S, 8'h13);
        check("t1_araddr", ARADDR_S, 32'h1000_0040);

        // 2: slot busy holds the pointer, then strict alternation
        ar_req = '1;
        #1 check("t2_stall", ar_grant, 0);
        step();
        check("t2_stall2", ar_grant, 0);
        ARREADY_S = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ARID_X[0] = IDW'($urandom); ARID_X[1] = IDW'($urandom);
            #1 check("t2_rr_grant", ar_grant, oh(i % 2));
            step();
            check("t2_rr_id", ARID_S, IDSW'(((i % 2) << IDW) | ARID_X[i % 2]));
        end
        ar_req = '0;
        step();

        // Random AR traffic against a pointer/slot reference
        ar_ptr = 0; ar_v = 1'b0; ar_id = '0;
        repeat (40) begin
            ar_req = M'($urandom); ARREADY_S = 1'($urandom);
            for (int m = 0; m < M; m++) ARID_X[m] = IDW'($urandom);
            #1;
            win = -1;
            if (!ar_v || ARREADY_S)
                for (int k = 0; k < M; k++)
                    if (win < 0 && ar_req[(ar_ptr + k) % M]) win = (ar_ptr + k) % M;
            check("ar_rand_grant", ar_grant, (win >= 0) ? oh(win) : '0);
            step();
            if (win >= 0) begin
                ar_v = 1'b1; ar_id = 8'((win << IDW) | ARID_X[win]); ar_ptr = (win + 1) % M;
            end else if (ARREADY_S) ar_v = 1'b0;
            check("ar_rand_valid", ARVALID_S, ar_v);
            if (ar_v) check("ar_rand_id", ARID_S, ar_id);
        end
        ar_req = '0; ARREADY_S = 1'b1;
        step();

        // 3/4: AW ordering and full-queue stall
        AWREADY_S = 1'b1; WREADY_S = 1'b1;
        aw_req = oh(0); AWID_X[0] = 4'h2; AWLEN_X[0] = 4'd3;
        #1 check("t3_aw0_grant", aw_grant, oh(0));
        step(); wq.push_back(0);
        check("t3_awid0", AWID_S, 8'h02);
        check("t3_awlen0", AWLEN_S, 3);
        aw_req = oh(1); AWID_X[1] = 4'h9; AWLEN_X[1] = 4'd1;
        #1 check("t3_aw1_grant", aw_grant, oh(1));
        step(); wq.push_back(1);
        check("t3_awid1", AWID_S, 8'h19);
        aw_req = oh(0); w_valid = oh(1);
        #1 check("t4_full_stall", aw_grant, 0);
        check("t3_early_wvalid", WVALID_S, 0);
        check("t3_early_wpop", w_pop, 0);
        step();
        for (int b = 0; b < 4; b++) begin
            w_valid = '1; WDATA_X[0] = $urandom; WDATA_X[1] = $urandom;
            WSTRB_X[0] = STW'($urandom); WLAST_X[0] = (b == 3); WLAST_X[1] = 1'b0;
            #1 check("t3_m0_wvalid", WVALID_S, 1);
            check("t3_m0_wpop", w_pop, oh(wq[0]));
            check("t3_m0_wdata", WDATA_S, WDATA_X[wq[0]]);
            check("t3_m0_wstrb", WSTRB_S, WSTRB_X[wq[0]]);
            check("t4_full_hold", aw_grant, 0);
            step();
            if (b == 3) void'(wq.pop_front());
        end
        for (int b = 0; b < 2; b++) begin
            WDATA_X[0] = $urandom; WDATA_X[1] = $urandom;
            WLAST_X[0] = 1'b0; WLAST_X[1] = (b == 1);
            #1 check("t3_m1_wpop", w_pop, oh(wq[0]));
            check("t3_m1_wdata", WDATA_S, WDATA_X[wq[0]]);
            check("t3_m1_wlast", WLAST_S, b == 1);
            if (b == 0) check("t4_regrant", aw_grant, oh(0));
            step();
            if (b == 0) wq.push_back(0);
            if (b == 1) void'(wq.pop_front());
            aw_req = '0;
        end
        WLAST_X[0] = 1'b1; WDATA_X[0] = $urandom;
        #1 check("t4_m0_tail_wpop", w_pop, oh(wq[0]));
        check("t4_m0_tail_wdata", WDATA_S, WDATA_X[wq[0]]);
        step(); void'(wq.pop_front());
        check("t3_q_drained", WVALID_S, 0);
        w_valid = '0;

        // 5: R burst back-to-back, then withheld pop
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                RVALID_S = 1'b1; RID_S = 8'h15; rd[k] = $urandom; RDATA_S = rd[k];
                RRESP_S = AXI_RESP_OKAY; RLAST_S = (k == 2);
            end else RVALID_S = 1'b0;
            r_pop = (k > 0) ? oh(1) : '0;
            #1 check("t5_rready", RREADY_S, 1);
            if (k > 0) begin
                check("t5_r_empty", r_empty, 0);
                check("t5_dest", r_dest_master, 1);
                check("t5_rid", RID, 5);
                check("t5_rdata", RDATA, rd[k-1]);
                check("t5_rlast", RLAST, k == 3);
            end
            step();
        end
        r_pop = '0;
        check("t5_drained", r_empty, 1);
        RVALID_S = 1'b1; RID_S = 8'h07; held = $urandom; RDATA_S = held;
        step();
        RDATA_S = ~held;
        check("t5_withheld_rready", RREADY_S, 0);
        check("t5_withheld_dest", r_dest_master, 0);
        check("t5_withheld_rid", RID, 7);
        step();
        check("t5_withheld_hold", RDATA, held);
        RVALID_S = 1'b0; r_pop = oh(0);
        step();
        r_pop = '0;
        check("t5_withheld_drain", r_empty, 1);

        // Random R traffic against a response scoreboard
        repeat (60) begin
            RVALID_S = 1'($urandom); RID_S = IDSW'($urandom); RDATA_S = $urandom;
            RLAST_S = 1'($urandom); RRESP_S = 2'($urandom);
            if (sq_data.size() > 0 && ($urandom % 3) != 0) r_pop = oh(sq_dest[0]);
            else if (sq_data.size() == 0 && ($urandom % 4) == 0) r_pop = oh($urandom % M);
            else r_pop = '0;
            #1;
            exp_ready = (sq_data.size() == 0) || (|r_pop);
            check("r_rand_ready", RREADY_S, exp_ready);
            check("r_rand_empty", r_empty, sq_data.size() == 0);
            if (sq_data.size() > 0) begin
                check("r_rand_dest", r_dest_master, sq_dest[0]);
                check("r_rand_rid", RID, sq_id[0]);
                check("r_rand_data", RDATA, sq_data[0]);
            end
            step();
            if ((|r_pop) && sq_data.size() > 0) begin
                void'(sq_dest.pop_front()); void'(sq_id.pop_front()); void'(sq_data.pop_front());
            end
            if (RVALID_S && exp_ready) begin
                sq_dest.push_back(int'(RID_S[IDW])); sq_id.push_back(RID_S[IDW-1:0]);
                sq_data.push_back(RDATA_S);
            end
        end
        RVALID_S = 1'b0;
        r_pop = (sq_data.size() > 0) ? oh(sq_dest[0]) : '0;
        step();
        r_pop = '0;

        // B slice
        BVALID_S = 1'b1; BID_S = 8'h1A; BRESP_S = AXI_RESP_SLVERR;
        #1 check("b_ready_empty", BREADY_S, 1);
        step();
        BVALID_S = 1'b0;
        check("b_not_empty", b_empty, 0);
        check("b_dest", b_dest_master, 1);
        check("b_bid", BID, 4'hA);
        check("b_bresp", BRESP, AXI_RESP_SLVERR);
        check("b_ready_full", BREADY_S, 0);
        b_pop = oh(1);
        #1 check("b_ready_pop", BREADY_S, 1);
        step();
        b_pop = '0;
        check("b_drained", b_empty, 1);

        // 6: asynchronous reset mid-burst
        ar_req = oh(0); ARREADY_S = 1'b1; aw_req = oh(0); AWREADY_S = 1'b0; WREADY_S = 1'b0;
        step();
        ar_req = '0; aw_req = '0; ARREADY_S = 1'b0; w_valid = '1;
        #1 check("t6_pre_arvalid", ARVALID_S, 1);
        check("t6_pre_wvalid", WVALID_S, 1);
        ARESETn = 1'b0;
        #1 check("t6_rst_arvalid", ARVALID_S, 0);
        check("t6_rst_wvalid", WVALID_S, 0);
        check("t6_rst_awvalid", AWVALID_S, 0);
        step(); step();
        ARESETn = 1'b1;
        #1 check("t6_q_empty", WVALID_S, 0);
        ar_req = '1; aw_req = '1; ARREADY_S = 1'b1; AWREADY_S = 1'b1;
        #1 check("t6_ar_ptr0", ar_grant, oh(0));
        check("t6_aw_ptr0", aw_grant, oh(0));
        step();
        ar_req = '0; aw_req = '0; w_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
